data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: WIDTH, 32, data/address width.
REQ-002 Parameter: SETS, 32, number of direct-mapped one-word lines; power of two.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 MemRead  in  1  CPU load request.
REQ-006 MemWrite  in  1  CPU store request.
REQ-007 LoadSrc  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-008 LoadSign  in  1  load extension: 0 zero-extend, 1 sign-extend.
REQ-009 ALUResult  in  WIDTH  byte address.
REQ-010 WriteData  in  WIDTH  store data, right-aligned.
REQ-011 ReadData  out  WIDTH  extended load result.
REQ-012 Stall  out  1  CPU must hold request and pipeline while high.
REQ-013 Misaligned  out  1  access violates size alignment.
REQ-014 mem_req  out  1  backing-memory request, held until mem_ack.
REQ-015 mem_we  out  1  1 write, 0 read.
REQ-016 mem_addr  out  WIDTH  word-aligned address (bits[1:0]=0).
REQ-017 mem_wdata  out  WIDTH  lane-positioned store data.
REQ-018 mem_wstrb  out  4  byte-lane enables.
REQ-019 mem_rdata  in  WIDTH  refill word, valid when mem_ack high.
REQ-020 mem_ack  in  1  one-cycle completion pulse, any latency >=1 cycle.

Function
REQ-021 Address split: offset [1:0], index [log2(SETS)+1:2], tag = remaining upper bits; each line holds valid, tag, 32-bit word.
REQ-022 FSM states IDLE, REFILL, WRITE; transitions only on posedge clk.
REQ-023 IDLE, MemWrite=1, aligned -> WRITE (MemWrite has priority over MemRead).
REQ-024 IDLE, MemRead=1, aligned, miss -> REFILL; read hit stays IDLE.
REQ-025 REFILL -> IDLE on mem_ack, writing mem_rdata, tag, valid=1 into the indexed line at that edge.
REQ-026 WRITE -> IDLE on mem_ack; if the line hits, merge strobed bytes into the line at that edge; a miss leaves the line unchanged (no write-allocate).
REQ-027 Read hit latency 0: ReadData valid combinationally in the request cycle, Stall=0.
REQ-028 Stall = (IDLE & aligned & (MemWrite | (MemRead & miss))) | REFILL | (WRITE & ~mem_ack).
REQ-029 The refilled load completes in the first IDLE cycle after the mem_ack edge as a hit.
REQ-030 mem_req=1 exactly in REFILL and WRITE; mem_we=1 only in WRITE; mem_addr/wdata/wstrb stable while mem_req=1.
REQ-031 Strobes: word 1111; half 0011 at offset 0, 1100 at offset 2; byte one-hot at offset; mem_wdata replicates data into the selected lanes.
REQ-032 Load lane select uses offset; sign bit is the MSB of the selected byte/half.
REQ-033 Misaligned=1 combinationally for half at odd offset or word at nonzero offset; the access is dropped (no state change, Stall=0, ReadData=0).
REQ-034 mem_ack outside REFILL/WRITE is ignored.
REQ-035 With no request in IDLE: Stall=0, ReadData=0.

Reset
REQ-036 rst at any edge: state IDLE, all valid bits 0; mem_req, mem_we, Stall and Misaligned are 0 in the following cycle; tag/data arrays are not reset.
REQ-037 Reset during REFILL/WRITE abandons the transaction; a late mem_ack is ignored under REQ-034.

Structure
REQ-038 Shared package riscv_mem_pkg holds the LoadSrc encodings, the cache_state_t enum, and the strobe width constant.
REQ-039 One sub-module, load_extend (lane select plus sign/zero extension), shared with the writeback stage.

Verification
REQ-040 After reset, lw 0x100 with a 3-cycle ack and mem_rdata=0xDEADBEEF -> Stall high for 4 cycles, then ReadData=0xDEADBEEF with Stall=0.
REQ-041 Repeat lw 0x100 -> hit, Stall=0, mem_req never asserted.
REQ-042 lb 0x103 LoadSign=1 on a line holding 0x80FF1234 -> ReadData=0xFFFFFF80; with LoadSign=0 -> 0x00000080.
REQ-043 sh 0x102 data 0x0000ABCD on a cached line -> mem_wstrb=1100, mem_wdata[31:16]=0xABCD, line becomes 0xABCDxxxx, next lw hits with the new value.
REQ-044 lw 0x101 -> Misaligned=1, Stall=0, no mem_req.
REQ-045 rst asserted mid-REFILL, then ack arrives -> line stays invalid, and the next lw to the same address misses.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : riscv_mem_pkg                                                    |
// | Purpose  : Shared memory-stage definitions: load/store size encodings,      |
// |            data-cache controller states and byte-strobe width.              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package riscv_mem_pkg;

  // Access size encodings carried on LoadSrc; 2'b11 is decoded as word.
  localparam logic [1:0] c_ls_word = 2'b00;
  localparam logic [1:0] c_ls_half = 2'b01;
  localparam logic [1:0] c_ls_byte = 2'b10;

  // Byte lanes per memory word.
  localparam int c_strb_w = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } cache_state_t;

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_extend                                                      |
// | Purpose  : Selects the addressed byte/half/word lane of a memory word and   |
// |            zero- or sign-extends it to the full data width.                 |
// | Ports    : word      in   raw 32-bit memory word                            |
// |            offset    in   byte offset within the word                       |
// |            load_src  in   access size (word/half/byte, 11 = word)           |
// |            load_sign in   1 = sign-extend, 0 = zero-extend                  |
// |            result    out  right-aligned, extended load value                |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module load_extend
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       offset,
  input  logic [1:0]       load_src,
  input  logic             load_sign,
  output logic [WIDTH-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{offset, 3'b000} +: 8];
    // Halves are only legal at offsets 0 and 2, so offset[1] picks the lane.
    w_half = offset[1] ? word[31:16] : word[15:0];
    case (load_src)
      c_ls_half: result = {{(WIDTH-16){load_sign & w_half[15]}}, w_half};
      c_ls_byte: result = {{(WIDTH-8){load_sign & w_byte[7]}}, w_byte};
      default:   result = word;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_cache                                                       |
// | Purpose  : Direct-mapped, one-word-per-line, write-through/no-allocate      |
// |            data cache with zero-latency read hits.                          |
// | Ports    : clk, rst                       clock, sync active-high reset     |
// |            MemRead/MemWrite               CPU load/store request            |
// |            LoadSrc/LoadSign               access size, load extension       |
// |            ALUResult/WriteData            byte address, store data          |
// |            ReadData/Stall/Misaligned      CPU-side results                  |
// |            mem_req/we/addr/wdata/wstrb    backing-memory request            |
// |            mem_rdata/mem_ack              backing-memory response           |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module data_cache
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SETS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [1:0]          LoadSrc,
  input  logic                LoadSign,
  input  logic [WIDTH-1:0]    ALUResult,
  input  logic [WIDTH-1:0]    WriteData,
  output logic [WIDTH-1:0]    ReadData,
  output logic                Stall,
  output logic                Misaligned,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic [c_strb_w-1:0] mem_wstrb,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = WIDTH - INDEX_W - 2;

  cache_state_t r_state, w_next;

  logic [SETS-1:0]     r_valid;
  logic [TAG_W-1:0]    r_tag  [SETS];
  logic [WIDTH-1:0]    r_data [SETS];

  // Transaction registers: hold the memory request steady while mem_req is high.
  logic [WIDTH-1:0]    r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [c_strb_w-1:0] r_wstrb;

  logic [1:0]          w_offset;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_r_index;
  logic [TAG_W-1:0]    w_r_tag;
  logic                w_aligned;
  logic                w_hit;
  logic                w_store_hit;
  logic [WIDTH-1:0]    w_line;
  logic [WIDTH-1:0]    w_ext;
  logic [WIDTH-1:0]    w_lane_data;
  logic [c_strb_w-1:0] w_lane_strb;
  logic                w_capture;
  logic                w_refill_wr;
  logic                w_store_wr;

  assign w_offset  = ALUResult[1:0];
  assign w_index   = ALUResult[INDEX_W+1:2];
  assign w_tag     = ALUResult[WIDTH-1:INDEX_W+2];
  assign w_r_index = r_addr[INDEX_W+1:2];
  assign w_r_tag   = r_addr[WIDTH-1:INDEX_W+2];

  assign w_line      = r_data[w_index];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_store_hit = r_valid[w_r_index] && (r_tag[w_r_index] == w_r_tag);

  // Alignment check plus store lane placement, both keyed on access size.
  always_comb begin
    w_aligned   = (w_offset == 2'b00);
    w_lane_data = WriteData;
    w_lane_strb = 4'b1111;
    case (LoadSrc)
      c_ls_half: begin
        w_aligned   = ~w_offset[0];
        w_lane_data = {2{WriteData[15:0]}};
        w_lane_strb = w_offset[1] ? 4'b1100 : 4'b0011;
      end
      c_ls_byte: begin
        w_aligned   = 1'b1;
        w_lane_data = {4{WriteData[7:0]}};
        w_lane_strb = 4'b0001 << w_offset;
      end
      default: ;
    endcase
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .word      (w_line),
    .offset    (w_offset),
    .load_src  (LoadSrc),
    .load_sign (LoadSign),
    .result    (w_ext)
  );

  assign Misaligned = (MemRead | MemWrite) & ~w_aligned;
  // Only a read hit in IDLE returns data; a write has priority over a read.
  assign ReadData   = (r_state == ST_IDLE && MemRead && !MemWrite && w_aligned && w_hit)
                      ? w_ext : '0;

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    Stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    w_capture   = 1'b0;
    w_refill_wr = 1'b0;
    w_store_wr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MemWrite && w_aligned) begin
          w_next    = ST_WRITE;
          Stall     = 1'b1;
          w_capture = 1'b1;
        end else if (MemRead && w_aligned && !w_hit) begin
          w_next    = ST_REFILL;
          Stall     = 1'b1;
          w_capture = 1'b1;
        end
      end
      ST_REFILL: begin
        mem_req = 1'b1;
        // Stays stalled through the ack cycle; the load retires as a hit next cycle.
        Stall   = 1'b1;
        if (mem_ack) begin
          w_next      = ST_IDLE;
          w_refill_wr = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        Stall   = ~mem_ack;
        if (mem_ack) begin
          w_next     = ST_IDLE;
          w_store_wr = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_addr  <= {ALUResult[WIDTH-1:2], 2'b00};
      r_wdata <= w_lane_data;
      r_wstrb <= w_lane_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_valid <= '0;
    else if (w_refill_wr) r_valid[w_r_index] <= 1'b1;
  end

  // Tag/data arrays carry no reset; a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (w_refill_wr) begin
      r_data[w_r_index] <= mem_rdata;
      r_tag[w_r_index]  <= w_r_tag;
    end else if (w_store_wr && w_store_hit) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (r_wstrb[b]) r_data[w_r_index][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule : data_cache
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_cache                                                    |
// | Purpose  : Self-checking bench for data_cache with a backing-memory model.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_data_cache;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, LoadSign;
  logic [1:0]  LoadSrc;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Misaligned;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;

  always #5 clk = ~clk;

  data_cache #(.WIDTH(32), .SETS(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .LoadSrc    (LoadSrc),
    .LoadSign   (LoadSign),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .Misaligned (Misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // Backing memory: acks after mem_req has been high for ack_lat cycles.
  logic [31:0] mem [logic [31:0]];
  int          ack_lat    = 1;
  int          req_run    = 0;
  int          req_total  = 0;
  int          stray_req  = 0;
  int          stray_done = 0;
  logic [31:0] last_addr, last_wdata, m_word;
  logic [3:0]  last_wstrb;
  logic        last_we;

  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (stray_req != stray_done) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      stray_done++;
    end else if (mem_req) begin
      req_total++;
      req_run++;
      if (req_run >= ack_lat) begin
        req_run    = 0;
        mem_ack    = 1'b1;
        last_addr  = mem_addr;
        last_we    = mem_we;
        last_wdata = mem_wdata;
        last_wstrb = mem_wstrb;
        m_word     = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) m_word[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = m_word;
        end else begin
          mem_rdata = m_word;
        end
      end
    end else begin
      req_run = 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access held until Stall drops; returns the data seen then and the stall count.
  task automatic access(input logic rd, input logic wr, input logic [1:0] src,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output int stalls);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; LoadSrc = src; LoadSign = sg;
    ALUResult = a; WriteData = wd;
    #1;
    stalls = 0;
    while (Stall && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("access_timeout", 32'(stalls < 50), 32'd1);
    rdata = ReadData;
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  src;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] rdv;
  int          st, t0;

  initial begin
    // Line 0x100 holds 0x80FF1234 when this table runs.
    vecs[0]  = '{"lb103s",   1, 0, c_ls_byte, 1, 32'h103, 32'hFFFFFF80, 0};
    vecs[1]  = '{"lb103u",   1, 0, c_ls_byte, 0, 32'h103, 32'h00000080, 0};
    vecs[2]  = '{"lb100s",   1, 0, c_ls_byte, 1, 32'h100, 32'h00000034, 0};
    vecs[3]  = '{"lb102s",   1, 0, c_ls_byte, 1, 32'h102, 32'hFFFFFFFF, 0};
    vecs[4]  = '{"lb101u",   1, 0, c_ls_byte, 0, 32'h101, 32'h00000012, 0};
    vecs[5]  = '{"lh102s",   1, 0, c_ls_half, 1, 32'h102, 32'hFFFF80FF, 0};
    vecs[6]  = '{"lh102u",   1, 0, c_ls_half, 0, 32'h102, 32'h000080FF, 0};
    vecs[7]  = '{"lh100s",   1, 0, c_ls_half, 1, 32'h100, 32'h00001234, 0};
    vecs[8]  = '{"lw101mis", 1, 0, c_ls_word, 0, 32'h101, 32'h00000000, 1};
    vecs[9]  = '{"lh103mis", 1, 0, c_ls_half, 1, 32'h103, 32'h00000000, 1};
    vecs[10] = '{"sw102mis", 0, 1, c_ls_word, 0, 32'h102, 32'h00000000, 1};
    vecs[11] = '{"lw100",    1, 0, c_ls_word, 0, 32'h100, 32'h80FF1234, 0};
    vecs[12] = '{"lsrc11",   1, 0, 2'b11,     1, 32'h100, 32'h80FF1234, 0};
    vecs[13] = '{"noreq",    0, 0, c_ls_word, 0, 32'h100, 32'h00000000, 0};

    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h22222222;
    mem[32'h188] = 32'h0BADF00D;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; LoadSrc = c_ls_word;
    LoadSign = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall",  32'(Stall),      32'd0);
    chk("rst_req",    32'(mem_req),    32'd0);
    chk("rst_we",     32'(mem_we),     32'd0);
    chk("rst_mis",    32'(Misaligned), 32'd0);
    chk("rst_rdata",  ReadData,        32'h0);
    rst = 1'b0;

    // Cold miss with 3-cycle ack.
    ack_lat = 3;
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("miss_stalls", 32'(st), 32'd4);
    chk("miss_rdata",  rdv, 32'hDEADBEEF);

    // Repeat is a hit with no memory traffic.
    t0 = req_total;
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("hit_stalls", 32'(st), 32'd0);
    chk("hit_rdata",  rdv, 32'hDEADBEEF);
    chk("hit_noreq",  32'(req_total - t0), 32'd0);

    // Word store hit, 2-cycle ack.
    ack_lat = 2;
    access(0, 1, c_ls_word, 0, 32'h100, 32'h80FF1234, rdv, st);
    chk("sw_stalls", 32'(st), 32'd2);
    chk("sw_addr",   last_addr, 32'h100);
    chk("sw_we",     32'(last_we), 32'd1);
    chk("sw_strb",   32'(last_wstrb), 32'hF);

    // Table of zero-latency hits, misaligned drops and idle.
    t0 = req_total;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      MemRead = vecs[i].rd; MemWrite = vecs[i].wr; LoadSrc = vecs[i].src;
      LoadSign = vecs[i].sg; ALUResult = vecs[i].addr; WriteData = 32'h5555AAAA;
      #1;
      chk({vecs[i].name, "_rdata"}, ReadData, vecs[i].exp_rdata);
      chk({vecs[i].name, "_stall"}, 32'(Stall), 32'd0);
      chk({vecs[i].name, "_mis"},   32'(Misaligned), 32'(vecs[i].exp_mis));
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("table_noreq", 32'(req_total - t0), 32'd0);

    // Halfword store at offset 2 merges into the cached line.
    ack_lat = 1;
    access(0, 1, c_ls_half, 0, 32'h102, 32'h0000ABCD, rdv, st);
    chk("sh_stalls", 32'(st), 32'd1);
    chk("sh_addr",   last_addr, 32'h100);
    chk("sh_strb",   32'(last_wstrb), 32'hC);
    chk("sh_wdhi",   32'(last_wdata[31:16]), 32'hABCD);
    t0 = req_total;
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("sh_lw_stalls", 32'(st), 32'd0);
    chk("sh_lw_rdata",  rdv, 32'hABCD1234);
    chk("sh_lw_noreq",  32'(req_total - t0), 32'd0);

    // Byte store at offset 1.
    access(0, 1, c_ls_byte, 0, 32'h101, 32'h0000005A, rdv, st);
    chk("sb_strb",  32'(last_wstrb), 32'h2);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("sb_lw_rdata", rdv, 32'hABCD5A34);

    // Store miss does not allocate; the following load misses.
    access(0, 1, c_ls_word, 0, 32'h184, 32'h11223344, rdv, st);
    chk("swmiss_strb", 32'(last_wstrb), 32'hF);
    access(1, 0, c_ls_word, 0, 32'h184, 32'h0, rdv, st);
    chk("swmiss_lw_stalls", 32'(st), 32'd2);
    chk("swmiss_lw_rdata",  rdv, 32'h11223344);

    // Conflict eviction on index 0, then reload sees written-through data.
    access(1, 0, c_ls_word, 0, 32'h200, 32'h0, rdv, st);
    chk("conf_stalls", 32'(st), 32'd2);
    chk("conf_rdata",  rdv, 32'h22222222);
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("evict_stalls", 32'(st), 32'd2);
    chk("evict_rdata",  rdv, 32'hABCD5A34);

    // Reset in the middle of a refill, then a stray ack.
    ack_lat = 100;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; LoadSrc = c_ls_word; ALUResult = 32'h188;
    repeat (3) @(negedge clk);
    chk("midref_req", 32'(mem_req), 32'd1);
    rst = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midref_rst_req",   32'(mem_req), 32'd0);
    chk("midref_rst_we",    32'(mem_we), 32'd0);
    chk("midref_rst_stall", 32'(Stall), 32'd0);
    chk("midref_rst_mis",   32'(Misaligned), 32'd0);
    stray_req++;
    repeat (3) @(negedge clk);
    ack_lat = 1;
    access(1, 0, c_ls_word, 0, 32'h188, 32'h0, rdv, st);
    chk("postrst_stalls", 32'(st), 32'd2);
    chk("postrst_rdata",  rdv, 32'h0BADF00D);
    access(1, 0, c_ls_word, 0, 32'h100, 32'h0, rdv, st);
    chk("postrst_inval_stalls", 32'(st), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_cache
`default_nettype wire
